// File: rtl/biquad_pkg.sv
// biquad_pkg: shared types, Q-format constants and the rounding/saturation helper for the biquad family.
package biquad_pkg;

    localparam int DFLT_SAMPLE_WIDTH = 8;
    localparam int DFLT_COEF_WIDTH   = 16;
    localparam int DFLT_NUM_STAGES   = 4;
    localparam int DFLT_NUM_CHANNELS = 2;
    localparam int ONE               = 2 ** (DFLT_COEF_WIDTH - 2);

    typedef enum logic [2:0] {B0, B1, B2, A1, A2} coef_idx_e;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_e;

    // Round half up, drop the Q fraction bits, clamp to the signed sample range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int sample_width,
                                                     input int coef_width);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (coef_width - 3))) >>> (coef_width - 2);
        hi = (64'sd1 <<< (sample_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sample_width - 1));
        return r > hi ? hi : r < lo ? lo : r;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// biquad_mac: signed multiply-accumulate with clear/add/subtract control and rounded, saturated output.
module biquad_mac
    import biquad_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DFLT_SAMPLE_WIDTH,
    parameter int COEF_WIDTH   = DFLT_COEF_WIDTH,
    localparam int ACC_W       = SAMPLE_WIDTH + COEF_WIDTH + 3
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           clear,
    input  logic                           sub,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    input  logic signed [COEF_WIDTH-1:0]   coef,
    output logic signed [SAMPLE_WIDTH-1:0] y
);

    logic signed [SAMPLE_WIDTH+COEF_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]                   term;
    logic signed [ACC_W-1:0]                   acc;

    // Full-precision product, sign-extended and optionally negated for the feedback taps.
    always_comb begin
        prod = sample * coef;
        term = sub ? -ACC_W'(prod) : ACC_W'(prod);
        y    = SAMPLE_WIDTH'(round_sat(64'(acc), SAMPLE_WIDTH, COEF_WIDTH));
    end

    // Accumulator: clear restarts the sum with the current product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else if (en) acc <= (clear ? '0 : acc) + term;
    end

endmodule

// File: rtl/biquad_cascade_tdm.sv
// biquad_cascade_tdm: multi-channel cascade of DF-I biquads sharing one time-multiplexed multiplier.
module biquad_cascade_tdm
    import biquad_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DFLT_SAMPLE_WIDTH,
    parameter int COEF_WIDTH   = DFLT_COEF_WIDTH,
    parameter int NUM_STAGES   = DFLT_NUM_STAGES,
    parameter int NUM_CHANNELS = DFLT_NUM_CHANNELS,
    localparam int CHAN_W      = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
    localparam int STAGE_W     = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [SAMPLE_WIDTH-1:0] in_data,
    input  logic [CHAN_W-1:0]              in_chan,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [SAMPLE_WIDTH-1:0] out_data,
    output logic [CHAN_W-1:0]              out_chan,
    output logic                           out_valid,
    input  logic                           coef_we,
    input  logic [STAGE_W-1:0]             coef_stage,
    input  logic [2:0]                     coef_idx,
    input  logic signed [COEF_WIDTH-1:0]   coef_data,
    input  logic                           coef_commit,
    output logic                           busy
);

    localparam logic signed [COEF_WIDTH-1:0] UNITY = COEF_WIDTH'(1) << (COEF_WIDTH - 2);

    state_e state, next_state;
    logic [2:0]                     tap;
    logic [STAGE_W-1:0]             sec;
    logic [CHAN_W-1:0]              chan;
    logic signed [SAMPLE_WIDTH-1:0] x, operand, y;
    logic signed [COEF_WIDTH-1:0]   coef;
    logic signed [SAMPLE_WIDTH-1:0] x1 [NUM_CHANNELS][NUM_STAGES];
    logic signed [SAMPLE_WIDTH-1:0] x2 [NUM_CHANNELS][NUM_STAGES];
    logic signed [SAMPLE_WIDTH-1:0] y1 [NUM_CHANNELS][NUM_STAGES];
    logic signed [SAMPLE_WIDTH-1:0] y2 [NUM_CHANNELS][NUM_STAGES];
    logic signed [COEF_WIDTH-1:0]   shadow    [NUM_STAGES][5];
    logic signed [COEF_WIDTH-1:0]   shadow_nx [NUM_STAGES][5];
    logic signed [COEF_WIDTH-1:0]   active    [NUM_STAGES][5];
    logic idle_like, chan_ok, accept, last_tap, last_sec, coef_ok, copy, commit_pending;

    // Handshake, status and the tap operand/coefficient mux feeding the shared multiplier.
    always_comb begin
        idle_like = state == S_IDLE || state == S_OUT;
        in_ready  = !reset && idle_like;
        busy      = !idle_like;
        out_valid = state == S_OUT;
        chan_ok   = 32'(in_chan) < NUM_CHANNELS;
        accept    = in_valid && in_ready && chan_ok;
        last_tap  = tap == 3'(A2);
        last_sec  = sec == STAGE_W'(NUM_STAGES - 1);
        operand   = tap == 3'(B0) ? x :
                    tap == 3'(B1) ? x1[chan][sec] :
                    tap == 3'(B2) ? x2[chan][sec] :
                    tap == 3'(A1) ? y1[chan][sec] : y2[chan][sec];
        coef      = active[sec][tap];
    end

    // FSM state register; an out-of-range channel is consumed without leaving idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= next_state;
    end

    // Next state: idle -> 5 MAC taps -> writeback, repeated per section, then one output cycle.
    always_comb begin
        next_state = idle_like ? (accept ? S_MAC : S_IDLE) :
                     state == S_MAC ? (last_tap ? S_WB : S_MAC) :
                     state == S_WB ? (last_sec ? S_OUT : S_MAC) : S_IDLE;
    end

    biquad_mac #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .COEF_WIDTH  (COEF_WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (state == S_MAC),
        .clear (tap == 3'(B0)),
        .sub   (tap >= 3'(A1)),
        .sample(operand),
        .coef  (coef),
        .y     (y)
    );

    // Sample latch, tap/section counters, per-channel section state and the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap      <= '0;
            sec      <= '0;
            chan     <= '0;
            x        <= '0;
            out_data <= '0;
            out_chan <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int s = 0; s < NUM_STAGES; s++) begin
                    x1[c][s] <= '0;
                    x2[c][s] <= '0;
                    y1[c][s] <= '0;
                    y2[c][s] <= '0;
                end
        end else begin
            if (accept) begin
                x    <= in_data;
                chan <= in_chan;
                tap  <= '0;
                sec  <= '0;
            end
            if (state == S_MAC) tap <= tap + 3'd1;
            if (state == S_WB) begin
                x2[chan][sec] <= x1[chan][sec];
                x1[chan][sec] <= x;
                y2[chan][sec] <= y1[chan][sec];
                y1[chan][sec] <= y;
                x             <= y;
                tap           <= '0;
                sec           <= last_sec ? '0 : sec + STAGE_W'(1);
                if (last_sec) begin
                    out_data <= y;
                    out_chan <= chan;
                end
            end
        end
    end

    // Shadow write view; a commit takes effect in any idle-like cycle, including one that accepts.
    always_comb begin
        coef_ok   = coef_idx <= 3'(A2) && 32'(coef_stage) < NUM_STAGES;
        shadow_nx = shadow;
        if (coef_we && coef_ok) shadow_nx[coef_stage][coef_idx] = coef_data;
        copy      = idle_like && (commit_pending || coef_commit);
    end

    // Coefficient banks: same-cycle writes are included in the copy so they are not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_pending <= 1'b0;
            for (int s = 0; s < NUM_STAGES; s++)
                for (int i = 0; i < 5; i++) begin
                    shadow[s][i] <= i == 0 ? UNITY : '0;
                    active[s][i] <= i == 0 ? UNITY : '0;
                end
        end else begin
            shadow         <= shadow_nx;
            commit_pending <= copy ? 1'b0 : commit_pending || coef_commit;
            if (copy) active <= shadow_nx;
        end
    end

endmodule
